mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter that shares the single synchronous memory port (33-bit word: 32 data bits plus grubby tag) between the RISC-V pipeline (port 0) and a secondary master such as a loader or DMA engine (port 1). Port 0 has fixed priority. A starvation counter guarantees port 1 a grant after a bounded wait. A registered owner tag steers the 1-cycle-latency read data back to the requester that issued the read. The block sits between the Pipeline/secondary master and the memory instance in the SoC and simulation benches.

## Interface
Parameters:
- AWIDTH, 14, word-address width; memory depth is 2**AWIDTH words.
- STARVE_LIMIT, 8, maximum consecutive cycles port 1 can be denied while requesting; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- p0_valid / p1_valid  in  1  access request.
- p0_ready / p1_ready  out  1  grant; a transfer occurs in the cycle where valid & ready.
- p0_write / p1_write  in  1  1 = write, 0 = read.
- p0_wmask / p1_wmask  in  4  byte enables.
- p0_wdata / p1_wdata  in  32  write data.
- p0_wgrubby / p1_wgrubby  in  1  grubby tag written with the data.
- p0_addr / p1_addr  in  AWIDTH  word address.
- p0_rdata / p1_rdata  out  32  read data, qualified by rvalid.
- p0_rgrubby / p1_rgrubby  out  1  read grubby tag, qualified by rvalid.
- p0_rvalid / p1_rvalid  out  1  read data valid for this port.
- mem_valid, mem_write  out  1  memory request.
- mem_wmask  out  4  byte enables to memory.
- mem_wdata  out  32  write data to memory.
- mem_wgrubby  out  1  grubby tag to memory.
- mem_addr  out  AWIDTH  word address to memory.
- mem_rdata  in  32  memory read data, valid one cycle after a read.
- mem_rgrubby  in  1  memory read grubby tag.

## Operation
- force1 = (starve_cnt == STARVE_LIMIT).
- grant0 = p0_valid & !force1 & !rst.
- grant1 = p1_valid & (!p0_valid | force1) & !rst.
- pX_ready = grantX. Both grants are combinational and mutually exclusive.
- Memory mux: mem_valid = grant0 | grant1. mem_write, mem_wmask, mem_wdata, mem_wgrubby and mem_addr come from the granted port. When neither port is granted, all mem_* outputs are 0.
- Starvation counter starve_cnt:
  - width = clog2(STARVE_LIMIT+1); saturating.
  - Increments when p1_valid & !grant1.
  - Clears to 0 when grant1 is set or p1_valid is low.
- Read owner register q_Owner, values NONE / P0 / P1:
  - Loads P0 or P1 on a granted read (valid & ready & !write).
  - Loads NONE on any other cycle, including granted writes.
- Read return:
  - pX_rvalid = (q_Owner == PX).
  - mem_rdata and mem_rgrubby are forwarded to both ports unconditionally; only rvalid discriminates the owner.
  - Writes never produce an rvalid.
- Reset (async): starve_cnt = 0 and q_Owner = NONE. Every output is 0 while rst is high.
- Reset during a pending read: the pending rvalid is dropped and not replayed after reset.
- Simultaneous requests: port 0 wins unless force1 is set.
- STARVE_LIMIT = 1: under continuous requests from both ports, grants alternate p0, p1, p0, p1, …
- A granted port may change address, write and data every cycle. Back-to-back reads from alternating ports each return on the correct port.

## Timing
- Grant latency: 0 cycles (ready is combinational from valid).
- Read latency: 1 cycle. rvalid and data appear in the cycle after the granted read.
- Worst-case wait for port 1 under saturating port 0 traffic: STARVE_LIMIT cycles. Port 1 is granted in cycle STARVE_LIMIT+1 of its request.
- Port 0 loses at most 1 cycle per STARVE_LIMIT+1 cycles.
- Throughput: 1 access per cycle, no bubbles between grants.
- Deassertion of rst is asynchronous-safe only if it is released synchronously to clk by the top level; the block adds no synchronizer.

## Test plan
- Reset release, no requests -> mem_valid=0, both ready=0 and rvalid=0; starve_cnt=0.
- p0 read at addr 0x10, memory word 0xDEADBEEF with grubby 1 -> p0_ready=1 the same cycle. Next cycle: p0_rvalid=1, p0_rdata=0xDEADBEEF, p0_rgrubby=1, p1_rvalid=0.
- p1 write addr 0x20, wdata 0x12345678, wmask 4'b0011, p0 idle -> p1_ready=1 and mem_* mirror the p1 fields. Following cycle: no rvalid.
- p0_valid held continuously, p1_valid raised at cycle 0, STARVE_LIMIT=8 -> p1_ready=0 for cycles 0..7 and 1 in cycle 8, p0_ready=0 in cycle 8. starve_cnt reads 0 after cycle 8; p0 is granted again in cycle 9.
- Alternating reads p0@0x4 then p1@0x8 on consecutive cycles (p0 idle during the second) -> p0_rvalid in cycle 1 with word 0x4, p1_rvalid in cycle 2 with word 0x8.
- rst asserted in the cycle after a granted p1 read -> p1_rvalid=0 immediately. After rst release: no spurious rvalid and starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared synchronous memory port: port 0 has fixed priority,
// port 1 is guaranteed a grant after STARVE_LIMIT denied cycles. Read data returns one cycle later.
module mem_port_arbiter #(
   parameter int AWIDTH       = 14,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic              p0_write,
   input  logic [3:0]        p0_wmask,
   input  logic [31:0]       p0_wdata,
   input  logic              p0_wgrubby,
   input  logic [AWIDTH-1:0] p0_addr,
   output logic [31:0]       p0_rdata,
   output logic              p0_rgrubby,
   output logic              p0_rvalid,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic              p1_write,
   input  logic [3:0]        p1_wmask,
   input  logic [31:0]       p1_wdata,
   input  logic              p1_wgrubby,
   input  logic [AWIDTH-1:0] p1_addr,
   output logic [31:0]       p1_rdata,
   output logic              p1_rgrubby,
   output logic              p1_rvalid,
   output logic              mem_valid,
   output logic              mem_write,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   output logic              mem_wgrubby,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rgrubby
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_P0   = 2'd1,
      OWNER_P1   = 2'd2
   } owner_t;

   owner_t        owner_reg, owner_next;
   logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
   logic          force1, grant0, grant1;
   logic [1:0]    rvalid_vec;

   assign force1 = (starve_cnt_reg == CW'(STARVE_LIMIT));
   assign grant0 = p0_valid & ~force1 & ~rst;
   assign grant1 = p1_valid & (~p0_valid | force1) & ~rst;

   assign p0_ready = grant0;
   assign p1_ready = grant1;

   always_comb begin
      mem_valid   = grant0 | grant1;
      mem_write   = 1'b0;
      mem_wmask   = '0;
      mem_wdata   = '0;
      mem_wgrubby = 1'b0;
      mem_addr    = '0;
      if (grant0) begin
         mem_write   = p0_write;
         mem_wmask   = p0_wmask;
         mem_wdata   = p0_wdata;
         mem_wgrubby = p0_wgrubby;
         mem_addr    = p0_addr;
      end else if (grant1) begin
         mem_write   = p1_write;
         mem_wmask   = p1_wmask;
         mem_wdata   = p1_wdata;
         mem_wgrubby = p1_wgrubby;
         mem_addr    = p1_addr;
      end
   end

   // Saturates at STARVE_LIMIT; reaching it forces the next grant to port 1.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!p1_valid || grant1)
         starve_cnt_next = '0;
      else if (!force1)
         starve_cnt_next = starve_cnt_reg + 1'b1;
   end

   always_comb begin
      owner_next = OWNER_NONE;
      if (grant0 && !p0_write)
         owner_next = OWNER_P0;
      else if (grant1 && !p1_write)
         owner_next = OWNER_P1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_reg      <= OWNER_NONE;
         starve_cnt_reg <= '0;
      end else begin
         owner_reg      <= owner_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ret
         assign rvalid_vec[gi] = (owner_reg == ((gi == 0) ? OWNER_P0 : OWNER_P1));
      end
   endgenerate

   // Data is broadcast to both ports; only rvalid names the owner.
   assign p0_rvalid  = rvalid_vec[0];
   assign p1_rvalid  = rvalid_vec[1];
   assign p0_rdata   = rst ? '0 : mem_rdata;
   assign p1_rdata   = rst ? '0 : mem_rdata;
   assign p0_rgrubby = mem_rgrubby & ~rst;
   assign p1_rgrubby = mem_rgrubby & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model and a read-return scoreboard.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_valid, p0_ready, p0_write, p0_wgrubby, p0_rgrubby, p0_rvalid;
   logic [3:0]  p0_wmask;
   logic [31:0] p0_wdata, p0_rdata;
   logic [13:0] p0_addr;
   logic        p1_valid, p1_ready, p1_write, p1_wgrubby, p1_rgrubby, p1_rvalid;
   logic [3:0]  p1_wmask;
   logic [31:0] p1_wdata, p1_rdata;
   logic [13:0] p1_addr;
   logic        mem_valid, mem_write, mem_wgrubby, mem_rgrubby;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata, mem_rdata;
   logic [13:0] mem_addr;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   typedef struct {
      bit          port;
      logic [31:0] data;
      logic        grubby;
   } exp_t;
   exp_t sb[$];

   logic [32:0] mem_arr [0:255];

   always #5 clk = ~clk;

   mem_port_arbiter #(.AWIDTH(14), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write), .p0_wmask(p0_wmask),
      .p0_wdata(p0_wdata), .p0_wgrubby(p0_wgrubby), .p0_addr(p0_addr), .p0_rdata(p0_rdata),
      .p0_rgrubby(p0_rgrubby), .p0_rvalid(p0_rvalid),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write), .p1_wmask(p1_wmask),
      .p1_wdata(p1_wdata), .p1_wgrubby(p1_wgrubby), .p1_addr(p1_addr), .p1_rdata(p1_rdata),
      .p1_rgrubby(p1_rgrubby), .p1_rvalid(p1_rvalid),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_wgrubby(mem_wgrubby), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rgrubby(mem_rgrubby)
   );

   // Synchronous memory model: byte-masked writes, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_valid) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_arr[mem_addr[7:0]][32] <= mem_wgrubby;
         end else begin
            {mem_rgrubby, mem_rdata} <= mem_arr[mem_addr[7:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_p0(input bit v, input bit w, input logic [13:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit g);
      p0_valid = v; p0_write = w; p0_addr = a; p0_wdata = d; p0_wmask = m; p0_wgrubby = g;
   endtask

   task automatic set_p1(input bit v, input bit w, input logic [13:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit g);
      p1_valid = v; p1_write = w; p1_addr = a; p1_wdata = d; p1_wmask = m; p1_wgrubby = g;
   endtask

   task automatic idle();
      set_p0(0, 0, 14'h0, 32'h0, 4'h0, 0);
      set_p1(0, 0, 14'h0, 32'h0, 4'h0, 0);
   endtask

   // Closes the current cycle and checks whatever read return the scoreboard expects.
   task automatic cycle_end();
      exp_t e;
      $display("txn %0d: p0v=%b p0r=%b p1v=%b p1r=%b mem_valid=%b mem_write=%b mem_addr=%0h",
               txn, p0_valid, p0_ready, p1_valid, p1_ready, mem_valid, mem_write, mem_addr);
      txn++;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("p0_rvalid", p0_rvalid, e.port == 1'b0);
         chk("p1_rvalid", p1_rvalid, e.port == 1'b1);
         chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
         chk("rgrubby", e.port ? p1_rgrubby : p0_rgrubby, e.grubby);
      end else begin
         chk("no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      mem_arr[8'h10] = {1'b1, 32'hDEADBEEF};
      mem_arr[8'h04] = {1'b0, 32'hA5A50004};
      mem_arr[8'h08] = {1'b1, 32'h5A5A0008};
      mem_rdata   = '0;
      mem_rgrubby = 1'b0;
      idle();

      // Outputs held at zero during reset even with a request present.
      set_p0(1, 0, 14'h10, 32'h0, 4'h0, 0);
      #1;
      chk("rst_p0_ready", p0_ready, 1'b0);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 14'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      #1;
      chk("idle_mem_valid", mem_valid, 1'b0);
      chk("idle_ready", {p0_ready, p1_ready}, 2'b00);
      chk("idle_starve", dut.starve_cnt_reg, 4'd0);
      cycle_end();

      // p0 read of 0x10.
      set_p0(1, 0, 14'h10, 32'h0, 4'h0, 0);
      #1;
      chk("p0rd_ready", {p0_ready, p1_ready}, 2'b10);
      chk("p0rd_mem", {mem_valid, mem_write, mem_addr}, {1'b1, 1'b0, 14'h10});
      sb.push_back('{port: 1'b0, data: 32'hDEADBEEF, grubby: 1'b1});
      cycle_end();

      // p1 masked write of 0x20 while p0 idles.
      idle();
      set_p1(1, 1, 14'h20, 32'h12345678, 4'b0011, 1);
      #1;
      chk("p1wr_ready", {p0_ready, p1_ready}, 2'b01);
      chk("p1wr_mem", {mem_valid, mem_write, mem_wmask, mem_wgrubby, mem_addr, mem_wdata},
          {1'b1, 1'b1, 4'b0011, 1'b1, 14'h20, 32'h12345678});
      cycle_end();

      // Read back the masked write through p0.
      idle();
      set_p0(1, 0, 14'h20, 32'h0, 4'h0, 0);
      #1;
      chk("rb_ready", p0_ready, 1'b1);
      sb.push_back('{port: 1'b0, data: 32'h00005678, grubby: 1'b1});
      cycle_end();

      // Starvation: p0 writes every cycle, p1 requests from cycle 0 until granted.
      for (int c = 0; c <= 9; c++) begin
         set_p0(1, 1, 14'h40 + 14'(c), 32'(c), 4'hF, 0);
         set_p1(c <= 8, 1, 14'h80, 32'hCAFE0000, 4'hF, 0);
         #1;
         chk($sformatf("starve_p0_ready_c%0d", c), p0_ready, c != 8);
         chk($sformatf("starve_p1_ready_c%0d", c), p1_ready, c == 8);
         if (c == 8) chk("starve_mem_addr", mem_addr, 14'h80);
         cycle_end();
         if (c <= 8) chk($sformatf("starve_cnt_c%0d", c), dut.starve_cnt_reg, (c == 8) ? 0 : c + 1);
      end

      // Alternating reads p0@0x4 then p1@0x8.
      idle();
      set_p0(1, 0, 14'h4, 32'h0, 4'h0, 0);
      #1;
      chk("alt_p0_ready", p0_ready, 1'b1);
      sb.push_back('{port: 1'b0, data: 32'hA5A50004, grubby: 1'b0});
      cycle_end();
      idle();
      set_p1(1, 0, 14'h8, 32'h0, 4'h0, 0);
      #1;
      chk("alt_p1_ready", p1_ready, 1'b1);
      sb.push_back('{port: 1'b1, data: 32'h5A5A0008, grubby: 1'b1});
      cycle_end();

      // Reset right after a granted p1 read drops the pending return.
      idle();
      set_p1(1, 0, 14'h8, 32'h0, 4'h0, 0);
      #1;
      chk("rr_p1_ready", p1_ready, 1'b1);
      @(posedge clk);
      #1;
      set_p0(1, 1, 14'h1, 32'h1, 4'hF, 0);
      set_p1(1, 1, 14'h2, 32'h2, 4'hF, 0);
      rst = 1'b1;
      #1;
      chk("rr_p1_rvalid", p1_rvalid, 1'b0);
      chk("rr_p1_rdata", p1_rdata, 32'h0);
      chk("rr_ready", {p0_ready, p1_ready}, 2'b00);
      chk("rr_mem_valid", mem_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("rr_starve_in_rst", dut.starve_cnt_reg, 4'd0);
      rst = 1'b0;
      idle();
      #1;
      chk("rr_starve_after", dut.starve_cnt_reg, 4'd0);
      cycle_end();
      cycle_end();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
